// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_ctrl
//  Description : Scans the enabled channels of a downstream 8:1 mux in
//                ascending index order. For each enabled channel it drives
//                the select lines, waits SETTLE_CYC cycles for the mux
//                output to settle, then samples y into the work word. When
//                every enabled channel has been sampled, done pulses for one
//                cycle and data presents the captured word.
//  Ports       : clk           - sole clock, rising edge
//                rst_n         - synchronous active-low reset
//                start         - scan request, only honoured when idle
//                mask[7:0]     - channel enables, latched when start is taken
//                y             - output of the downstream 8:1 mux
//                s2,s1,s0      - mux select, {s2,s1,s0} = channel index
//                busy          - high from start acceptance through DONE
//                done          - one-cycle pulse, data valid
//                data[7:0]     - captured word, bit k = y on channel k
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] mask,
    input  logic       y,
    output logic       s2,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Terminal value of the settle counter, which counts 0..SETTLE_CYC-1.
    localparam logic [3:0] C_CNT_LAST = 4'(SETTLE_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_mask_q;
    logic [7:0] w_mask_q_nxt;
    logic [7:0] r_work;
    logic [7:0] w_work_nxt;
    logic [7:0] r_data;
    logic [7:0] w_data_nxt;
    logic [2:0] r_sel;
    logic [2:0] w_sel_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_find_first;
    logic [3:0] w_find_next;

    // Lowest set bit of m at index >= from. Result is {found, index}.
    // Scanning downward lets the lowest qualifying index win.
    function automatic logic [3:0] f_first_from(input logic [7:0] m,
                                                input logic [3:0] from);
        logic [3:0] res;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k] && (4'(k) >= from)) begin
                res = {1'b1, 3'(k)};
            end
        end
        return res;
    endfunction

    // The first search looks at the live mask because mask_q is only being
    // loaded on the same edge; later searches use the latched copy so that
    // mask changes during a scan have no effect.
    assign w_find_first = f_first_from(mask, 4'd0);
    assign w_find_next  = f_first_from(r_mask_q, {1'b0, r_sel} + 4'd1);

    always_comb begin
        w_state_nxt  = r_state;
        w_mask_q_nxt = r_mask_q;
        w_work_nxt   = r_work;
        w_data_nxt   = r_data;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mask_q_nxt = mask;
                    w_work_nxt   = 8'h00;
                    if (w_find_first[3]) begin
                        w_state_nxt = ST_SETTLE;
                        w_sel_nxt   = w_find_first[2:0];
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        // Empty mask: report an all-zero word straight away,
                        // select lines untouched.
                        w_state_nxt = ST_DONE;
                        w_data_nxt  = 8'h00;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_SAMPLE: begin
                w_work_nxt[r_sel] = y;
                if (w_find_next[3]) begin
                    w_state_nxt = ST_SETTLE;
                    w_sel_nxt   = w_find_next[2:0];
                    w_cnt_nxt   = 4'd0;
                end else begin
                    // Publish including the sample taken on this edge.
                    w_state_nxt = ST_DONE;
                    w_data_nxt  = w_work_nxt;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mask_q <= 8'h00;
            r_work   <= 8'h00;
            r_data   <= 8'h00;
            r_sel    <= 3'd0;
            r_cnt    <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_mask_q <= w_mask_q_nxt;
            r_work   <= w_work_nxt;
            r_data   <= w_data_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign data = r_data;
    assign s2   = r_sel[2];
    assign s1   = r_sel[1];
    assign s0   = r_sel[0];

endmodule
`default_nettype wire
